gpu_prefetch: RTL and testbench
===============================

GPU_PREFETCH -- requirements
Module: gpu_prefetch

Interface
REQ-001 Parameter QDEPTH, default 4, SHALL set the instruction queue depth in 16-bit words; only even values of 4 or more are legal.
REQ-002 Port clk, in, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 Port reset, in, 1: reset SHALL be asynchronous and active-high.
REQ-004 Port jump_load, in, 1: load a new fetch PC and flush the queue.
REQ-005 Port jump_addr, in, 24: new byte PC; bit 0 SHALL be ignored.
REQ-006 Port progreq, out, 1: program fetch request to the GPU memory interface.
REQ-007 Port progaddr, out, 22: longword fetch address, equal to fetch_pc[23:2].
REQ-008 Port progack, in, 1: the request is serviced and gpu_din is valid in the same cycle.
REQ-009 Port gpu_din, in, 32: fetched longword, big-endian, with the first instruction in bits 31:16.
REQ-010 Port pabort, out, 1: one-cycle abort of an outstanding fetch.
REQ-011 Port instr_valid, out, 1: the queue head is valid.
REQ-012 Port instr, out, 16: the queue head instruction word.
REQ-013 Port instr_pc, out, 24: byte address of the queue head (bit 0 = 0).
REQ-014 Port instr_take, in, 1: the consumer pops the head this cycle; ignored when instr_valid = 0.

Function
REQ-015 States SHALL be IDLE (no request outstanding) and WAIT (progreq held high).
REQ-016 IDLE->WAIT SHALL occur when free words ≥ 2 and jump_load = 0; progreq SHALL assert the next cycle and stay high until progack or abort.
REQ-017 progaddr SHALL be stable for as long as progreq is high.
REQ-018 WAIT->IDLE SHALL occur on progack. The queue SHALL then write {gpu_din[31:16], gpu_din[15:0]} in order and advance fetch_pc by 4.
REQ-019 If fetch_pc[1] = 1 at progack, only gpu_din[15:0] SHALL be written and fetch_pc SHALL advance by 2 to the next longword.
REQ-020 Data SHALL first be visible on instr/instr_valid the cycle after progack, giving one cycle of latency.
REQ-021 A simultaneous write and instr_take SHALL both take effect. The count SHALL change by (written words − 1) and SHALL never exceed QDEPTH.
REQ-022 The empty queue SHALL give instr_valid = 0; instr and instr_pc are don't-care while empty.
REQ-023 instr_pc SHALL increment by 2 per popped word and wrap modulo 2^24.
REQ-024 fetch_pc SHALL wrap modulo 2^24 without error.
REQ-025 On jump_load, the queue SHALL empty, fetch_pc := jump_addr & ~1, and the state SHALL go to IDLE.
REQ-026 Also on jump_load: if the state was WAIT, pabort = 1 for exactly that cycle; progreq SHALL drop the next cycle.
REQ-027 jump_load SHALL take priority over progack and instr_take in the same cycle: the ack data is discarded and no pop occurs.
REQ-028 A new request after a jump SHALL be no earlier than the cycle after jump_load.
REQ-029 Free-space accounting SHALL count only resident words, because at most one request is outstanding.

Reset
REQ-030 While reset = 1, all outputs SHALL hold 0: progreq, pabort, instr_valid, instr, instr_pc and progaddr.
REQ-031 While reset = 1, internal state SHALL hold: state IDLE, count 0, fetch_pc 0.
REQ-032 Reset asserted mid-WAIT SHALL drop progreq asynchronously; no pabort SHALL be generated.
REQ-033 The first progreq SHALL occur no earlier than the second clk edge after reset deasserts.

Structure
REQ-034 Shared package gpu_pkg SHALL hold the constants GPU_PC_W = 24, GPU_PROGADDR_W = 22, GPU_INSTR_W = 16 and PF_QDEPTH_DEF = 4.
REQ-035 gpu_pkg SHALL also hold the state enum pf_state_t {PF_IDLE, PF_WAIT}.
REQ-036 The storage SHALL be a sub-module gpu_pfq_fifo. It is a 16-bit circular buffer that writes 1 or 2 words per cycle, pops 1 per cycle and supports a synchronous flush.
REQ-037 The request FSM and PC logic SHALL stay in gpu_prefetch.

Verification
REQ-038 Jump sequence. Stimulus: jump_addr = 0xF03000, then ack with gpu_din = 0x12345678. Required: progaddr = 0x3C0C00; next cycle instr = 0x1234, instr_pc = 0xF03000; after a pop, instr = 0x5678, instr_pc = 0xF03002.
REQ-039 Odd-halfword jump. Stimulus: jump_addr = 0xF03002, ack with 0xAAAABBBB. Required: only 0xBBBB is queued, with instr_pc = 0xF03002; the next progaddr is 0x3C0C01.
REQ-040 Full queue. Stimulus: no instr_take, acks with 0x00010002 then 0x00030004. Required: count = 4; progreq stays low until one pop, and does not request yet since free = 1; after 2 pops progreq reasserts.
REQ-041 Jump on ack. Stimulus: jump_load and progack in the same cycle while in WAIT, ack data 0xDEADBEEF. Required: pabort = 1 for 1 cycle; queue empty; the data is never presented.
REQ-042 Reset mid-fetch. Stimulus: reset pulse during WAIT. Required: progreq = 0 immediately; instr_valid = 0; fetch_pc = 0; progaddr = 0.
REQ-043 PC wrap. Stimulus: jump_addr = 0xFFFFFC, ack twice. Required: the second progaddr is 0x000000; instr_pc runs 0xFFFFFC, 0xFFFFFE, 0x000000.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, queue depth default and prefetch FSM states
package gpu_pkg;
  localparam int GPU_PC_W = 24;
  localparam int GPU_PROGADDR_W = 22;
  localparam int GPU_INSTR_W = 16;
  localparam int PF_QDEPTH_DEF = 4;
  typedef enum logic {PF_IDLE, PF_WAIT} pf_state_t;
endpackage

// File: rtl/gpu_pfq_fifo.sv
// gpu_pfq_fifo: 16-bit circular buffer, 1-2 word write, 1 word pop, sync flush
// Ports: clk, reset (async), flush, wr_en/wr_two/wr_data0/wr_data1 write side,
// rd_en/rd_data/valid read side, count = resident words
module gpu_pfq_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = PF_QDEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic                   wr_two,
  input  logic [GPU_INSTR_W-1:0] wr_data0,
  input  logic [GPU_INSTR_W-1:0] wr_data1,
  input  logic                   rd_en,
  output logic [GPU_INSTR_W-1:0] rd_data,
  output logic [CW-1:0]          count,
  output logic                   valid
);
  logic [GPU_INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign wr_ptr1 = nxt(wr_ptr);
  assign valid = count != '0;
  assign pop = rd_en && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data0;
    if (wr_en && wr_two && !flush) mem[wr_ptr1] <= wr_data1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_two ? nxt(wr_ptr1) : wr_ptr1;
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr_en ? (wr_two ? 2 : 1) : 0) - CW'(pop);
    end
  end
endmodule

// File: rtl/gpu_prefetch.sv
// gpu_prefetch: GPU instruction prefetcher with one outstanding longword fetch
// Ports: clk, reset (async); jump_load/jump_addr redirect and flush;
// progreq/progaddr/progack/gpu_din/pabort memory side;
// instr_valid/instr/instr_pc/instr_take consumer side
module gpu_prefetch
  import gpu_pkg::*;
#(
  parameter int QDEPTH = PF_QDEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      jump_load,
  input  logic [GPU_PC_W-1:0]       jump_addr,
  output logic                      progreq,
  output logic [GPU_PROGADDR_W-1:0] progaddr,
  input  logic                      progack,
  input  logic [31:0]               gpu_din,
  output logic                      pabort,
  output logic                      instr_valid,
  output logic [GPU_INSTR_W-1:0]    instr,
  output logic [GPU_PC_W-1:0]       instr_pc,
  input  logic                      instr_take
);
  localparam int CW = $clog2(QDEPTH + 1);
  pf_state_t state, state_nx;
  logic ready, ack, pop, odd;
  logic [GPU_PC_W-1:0] fetch_pc, head_pc;
  logic [CW-1:0] count;
  assign odd = fetch_pc[1];
  assign ack = state == PF_WAIT && progack && !jump_load;
  assign pop = instr_take && instr_valid && !jump_load;
  assign progaddr = fetch_pc[GPU_PC_W-1:2];
  assign instr_pc = head_pc;
  // ready holds off the first request until the second edge after reset
  always_comb begin
    state_nx = state;
    progreq = state == PF_WAIT;
    pabort = state == PF_WAIT && jump_load;
    if (jump_load) state_nx = PF_IDLE;
    else if (state == PF_IDLE) state_nx = (ready && count <= CW'(QDEPTH - 2)) ? PF_WAIT : PF_IDLE;
    else state_nx = progack ? PF_IDLE : PF_WAIT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PF_IDLE;
      ready <= 1'b0;
      fetch_pc <= '0;
      head_pc <= '0;
    end else begin
      state <= state_nx;
      ready <= 1'b1;
      if (jump_load) begin
        fetch_pc <= jump_addr & ~GPU_PC_W'(1);
        head_pc <= jump_addr & ~GPU_PC_W'(1);
      end else begin
        if (ack) fetch_pc <= fetch_pc + (odd ? GPU_PC_W'(2) : GPU_PC_W'(4));
        if (pop) head_pc <= head_pc + GPU_PC_W'(2);
      end
    end
  end
  gpu_pfq_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(jump_load),
    .wr_en(ack),
    .wr_two(!odd),
    .wr_data0(odd ? gpu_din[15:0] : gpu_din[31:16]),
    .wr_data1(gpu_din[15:0]),
    .rd_en(pop),
    .rd_data(instr),
    .count(count),
    .valid(instr_valid)
  );
endmodule

// File: tb/tb_gpu_prefetch.sv
// tb_gpu_prefetch: directed scenarios plus randomized run against a queue model
module tb_gpu_prefetch;
  localparam int QDEPTH = 4;
  logic clk = 0, reset = 1, jump_load = 0, progack = 0, instr_take = 0;
  logic [23:0] jump_addr = 0;
  logic [31:0] gpu_din = 0;
  logic progreq, pabort, instr_valid;
  logic [21:0] progaddr;
  logic [15:0] instr;
  logic [23:0] instr_pc;
  int n_cmp = 0, n_bad = 0;

  gpu_prefetch #(.QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset), .jump_load(jump_load), .jump_addr(jump_addr),
    .progreq(progreq), .progaddr(progaddr), .progack(progack), .gpu_din(gpu_din),
    .pabort(pabort), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_take(instr_take)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_req();
    for (int i = 0; i < 8 && progreq !== 1'b1; i++) step();
  endtask

  task automatic do_jump(input logic [23:0] a);
    jump_load = 1;
    jump_addr = a;
    step();
    jump_load = 0;
  endtask

  task automatic do_ack(input logic [31:0] d);
    progack = 1;
    gpu_din = d;
    step();
    progack = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    n_cmp++;
    if ({progreq, pabort, instr_valid, instr, instr_pc, progaddr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b abort=%b valid=%b instr=%h pc=%h addr=%h, want all 0",
               progreq, pabort, instr_valid, instr, instr_pc, progaddr);
    end
    reset = 0;
    step();
    n_cmp++;
    if (progreq !== 1'b0) begin n_bad++; $display("FAIL reset_first_edge_req: got %b want 0", progreq); end
    step();
    n_cmp++;
    if (progreq !== 1'b1) begin n_bad++; $display("FAIL reset_second_edge_req: got %b want 1", progreq); end
  endtask

  task automatic test_jump();
    do_jump(24'hF03000);
    get_req();
    n_cmp++;
    if (progaddr !== 22'h3C0C00) begin n_bad++; $display("FAIL jump_progaddr: got %h want 3c0c00", progaddr); end
    do_ack(32'h12345678);
    n_cmp++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h1234, 24'hF03000}) begin
      n_bad++; $display("FAIL jump_head0: got v=%b %h @%h want 1 1234 @f03000", instr_valid, instr, instr_pc);
    end
    instr_take = 1;
    step();
    instr_take = 0;
    n_cmp++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h5678, 24'hF03002}) begin
      n_bad++; $display("FAIL jump_head1: got v=%b %h @%h want 1 5678 @f03002", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_odd_jump();
    do_jump(24'hF03002);
    get_req();
    do_ack(32'hAAAABBBB);
    n_cmp++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hBBBB, 24'hF03002}) begin
      n_bad++; $display("FAIL odd_head: got v=%b %h @%h want 1 bbbb @f03002", instr_valid, instr, instr_pc);
    end
    instr_take = 1;
    step();
    instr_take = 0;
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL odd_single_word: valid=%b want 0", instr_valid); end
    get_req();
    n_cmp++;
    if ({progreq, progaddr} !== {1'b1, 22'h3C0C01}) begin
      n_bad++; $display("FAIL odd_next_addr: got req=%b %h want 1 3c0c01", progreq, progaddr);
    end
  endtask

  task automatic test_full();
    do_jump(24'h000100);
    get_req();
    do_ack(32'h00010002);
    get_req();
    do_ack(32'h00030004);
    n_cmp++;
    if ({instr_valid, instr} !== {1'b1, 16'h0001}) begin n_bad++; $display("FAIL full_head: got %b %h want 1 0001", instr_valid, instr); end
    repeat (3) step();
    n_cmp++;
    if (progreq !== 1'b0) begin n_bad++; $display("FAIL full_no_req: got %b want 0", progreq); end
    instr_take = 1;
    step();
    instr_take = 0;
    repeat (3) step();
    n_cmp++;
    if ({progreq, instr} !== {1'b0, 16'h0002}) begin n_bad++; $display("FAIL full_free1: req=%b instr=%h want 0 0002", progreq, instr); end
    instr_take = 1;
    step();
    instr_take = 0;
    step();
    n_cmp++;
    if ({progreq, instr, progaddr} !== {1'b1, 16'h0003, 22'h000042}) begin
      n_bad++; $display("FAIL full_reassert: req=%b instr=%h addr=%h want 1 0003 000042", progreq, instr, progaddr);
    end
  endtask

  task automatic test_jump_on_ack();
    do_jump(24'h000100);
    get_req();
    jump_load = 1;
    jump_addr = 24'h000200;
    progack = 1;
    gpu_din = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (pabort !== 1'b1) begin n_bad++; $display("FAIL jack_abort: got %b want 1", pabort); end
    step();
    jump_load = 0;
    progack = 0;
    n_cmp++;
    if ({pabort, progreq, instr_valid} !== 3'b000) begin
      n_bad++; $display("FAIL jack_after: abort=%b req=%b valid=%b want 000", pabort, progreq, instr_valid);
    end
    repeat (3) step();
    n_cmp++;
    if ({instr_valid, progaddr} !== {1'b0, 22'h000080}) begin
      n_bad++; $display("FAIL jack_discard: valid=%b addr=%h want 0 000080", instr_valid, progaddr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_jump(24'h123456);
    get_req();
    reset = 1;
    #1;
    n_cmp++;
    if ({progreq, pabort, instr_valid, progaddr, instr_pc} !== '0) begin
      n_bad++; $display("FAIL rst_mid: req=%b abort=%b valid=%b addr=%h pc=%h want all 0",
                        progreq, pabort, instr_valid, progaddr, instr_pc);
    end
    step();
    reset = 0;
    step();
    n_cmp++;
    if (progreq !== 1'b0) begin n_bad++; $display("FAIL rst_mid_hold: req=%b want 0", progreq); end
  endtask

  task automatic test_wrap();
    do_jump(24'hFFFFFC);
    get_req();
    do_ack(32'h11112222);
    n_cmp++;
    if ({instr, instr_pc} !== {16'h1111, 24'hFFFFFC}) begin n_bad++; $display("FAIL wrap_pc0: %h @%h want 1111 @fffffc", instr, instr_pc); end
    get_req();
    n_cmp++;
    if ({progreq, progaddr} !== {1'b1, 22'h000000}) begin n_bad++; $display("FAIL wrap_addr: req=%b %h want 1 000000", progreq, progaddr); end
    do_ack(32'h33334444);
    instr_take = 1;
    step();
    n_cmp++;
    if ({instr, instr_pc} !== {16'h2222, 24'hFFFFFE}) begin n_bad++; $display("FAIL wrap_pc1: %h @%h want 2222 @fffffe", instr, instr_pc); end
    step();
    instr_take = 0;
    n_cmp++;
    if ({instr, instr_pc} !== {16'h3333, 24'h000000}) begin n_bad++; $display("FAIL wrap_pc2: %h @%h want 3333 @000000", instr, instr_pc); end
  endtask

  task automatic test_random();
    logic [15:0] qw[$];
    logic [23:0] qp[$];
    logic [23:0] fpc;
    bit req;
    int sz;
    fpc = {$urandom_range(0, 24'hFFFFFF)} & ~24'd1;
    do_jump(fpc);
    req = 0;
    for (int c = 0; c < 3000; c++) begin
      jump_load = ($urandom_range(0, 99) < 3);
      jump_addr = $urandom;
      instr_take = $urandom_range(0, 1);
      progack = req && ($urandom_range(0, 9) < 4);
      gpu_din = $urandom;
      #1;
      n_cmp++;
      if ({progreq, progaddr, pabort, instr_valid} !== {req, fpc[23:2], req && jump_load, qw.size() > 0}) begin
        n_bad++; $display("FAIL rnd_ctrl c=%0d: req=%b addr=%h abort=%b valid=%b want %b %h %b %b", c,
                          progreq, progaddr, pabort, instr_valid, req, fpc[23:2], req && jump_load, qw.size() > 0);
      end
      if (qw.size() > 0) begin
        n_cmp++;
        if ({instr, instr_pc} !== {qw[0], qp[0]}) begin
          n_bad++; $display("FAIL rnd_head c=%0d: %h @%h want %h @%h", c, instr, instr_pc, qw[0], qp[0]);
        end
      end
      sz = qw.size();
      if (jump_load) begin
        qw.delete();
        qp.delete();
        fpc = jump_addr & ~24'd1;
        req = 0;
      end else begin
        if (req && progack) begin
          if (fpc[1]) begin
            qw.push_back(gpu_din[15:0]); qp.push_back(fpc); fpc = fpc + 24'd2;
          end else begin
            qw.push_back(gpu_din[31:16]); qp.push_back(fpc);
            qw.push_back(gpu_din[15:0]); qp.push_back(fpc + 24'd2); fpc = fpc + 24'd4;
          end
          req = 0;
        end else if (!req && QDEPTH - sz >= 2) req = 1;
        if (instr_take && sz > 0) begin
          void'(qw.pop_front());
          void'(qp.pop_front());
        end
      end
      @(posedge clk);
      #1;
    end
    jump_load = 0;
    progack = 0;
    instr_take = 0;
  endtask

  initial begin
    test_reset();
    test_jump();
    test_odd_jump();
    test_full();
    test_jump_on_ack();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
